add16u_share_arb: RTL and testbench
===================================

# add16u_share_arb

Round-robin arbiter and sequencer that shares one 16-bit unsigned adder instance (17-bit result, combinational, exact or approximate) among several requesters. Each requester presents an operand pair on a valid/ready channel. The block selects one requester per cycle, drives the shared adder's A/B inputs, and captures the 17-bit sum into a one-entry result register. It returns the sum with the requester ID on a single valid/ready response channel. It sits between the accelerator's operand sources and the pre-characterised adder, so any adder variant can be swapped in without touching the requesters.

## Interface
- NREQ, 4: number of requesters (2..8).
- IDW, 2: response ID width, clog2(NREQ).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  grant enable; low blocks new grants, response drain continues.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  16*NREQ  operand A, requester i at bits [16i+15:16i].
- req_b  in  16*NREQ  operand B, same packing.
- add_a  out  16  to shared adder A.
- add_b  out  16  to shared adder B.
- add_o  in  17  from shared adder O (combinational, same cycle).
- rsp_valid  out  1  result register holds a result.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  17  captured sum.
- rsp_id  out  IDW  index of the requester that produced rsp_data.
- ops_total  out  16  count of accepted requests; wraps 0xFFFF -> 0x0000.
- busy  out  1  rsp_valid OR any req_valid while en is high.

## Operation
- Slot free condition: slot_free = !rsp_valid | rsp_ready.
- Grant eligibility: grant allowed iff en & slot_free & (|req_valid).
- Winner selection: first i with req_valid[i] high, scanning from pointer ptr upward, modulo NREQ.
- Handshake: req_ready[winner]=1 when grant allowed, all other bits 0. A request is accepted at the edge where req_valid[i] & req_ready[i].
- Adder drive: add_a/add_b = winner's operands when a grant is allowed, else 16'h0000. Only the winner's operands ever reach the adder; no glitch-free requirement.
- Accept edge actions:
  - rsp_data <= add_o
  - rsp_id <= winner
  - rsp_valid <= 1
  - ptr <= (winner+1) mod NREQ
  - ops_total += 1
- Response consumed with no accept: rsp_valid <= 0; rsp_data and rsp_id hold their last value.
- Simultaneous consume and accept in one cycle: the new result replaces the old one and rsp_valid stays 1.
- ptr changes only on an accept. With no grant, ptr holds.
- The block never inspects add_o. Width and arithmetic are whatever the attached adder produces; the 17-bit value is passed through unmodified.
- Requester obligations: req_a/req_b/req_valid stable while waiting. The block does not check this.
- Reset values, asserted asynchronously:
  - rsp_valid=0, rsp_data=0, rsp_id=0
  - ptr=0, ops_total=0
  - req_ready=0, add_a/add_b=0
- Reset mid-operation: any pending result is discarded. Requesters re-present after reset.

## Timing
- Latency: accept at edge N, rsp_valid=1 with result from cycle N+1.
- Throughput: one result per cycle while rsp_ready is held high.
- Combinational path: req_valid/rsp_ready/en -> req_ready, and req_* -> add_a/b -> add_o -> result register D input. The adder delay is budgeted inside this single cycle.
- No path from rsp_ready to rsp_valid within a cycle.
- Backpressure: rsp_ready low with rsp_valid high forces req_ready=0 and add_a/add_b=0. rsp_data/rsp_id stay stable until consumed.
- en deasserted: effective in the same cycle (req_ready=0). A result already in the register still drains.

## Test plan
- Single request: bench exact-adder model, req 1 presents A=0x1234, B=0x0FFF, rsp_ready=1. Expect req_ready=4'b0010 in the same cycle; next cycle rsp_valid=1, rsp_data=0x02233, rsp_id=1, ops_total=1.
- Round-robin fairness: all four valid from reset, rsp_ready=1. Expect grants in order 0,1,2,3,0 on consecutive cycles and back-to-back rsp_valid.
- Pointer rotation: grant 2, then req 0 and req 3 valid together. Expect 3 granted before 0.
- Backpressure: rsp_ready=0 for 5 cycles with a held result 0x1FFFE (A=B=0xFFFF). Expect req_ready=0 throughout and rsp_data stable. On release, the next grant happens in the same cycle as the consume.
- en low: all requests valid, en=0. Expect no req_ready and ops_total frozen; the pending result still drains.
- Reset mid-operation: assert rst_n=0 while rsp_valid=1 with ops_total=0x0005. Expect all outputs at their reset values immediately, and after release the first grant goes to requester 0.

Source files
------------

// File: rtl/add16u_share_arb.sv
// Round-robin arbiter that time-shares one external 16-bit adder among NREQ
// requesters and returns each 17-bit sum, tagged with its requester ID, through a one-entry result register.
module add16u_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [15:0]          add_a,
  output logic [15:0]          add_b,
  input  logic [16:0]          add_o,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [16:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          ops_total,
  output logic                 busy
);

  logic [IDW-1:0]    ptr_q, ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [16:0]       rsp_data_q, rsp_data_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [15:0]       ops_total_q, ops_total_d;

  logic [2*NREQ-1:0] valid_rot;
  logic [IDW:0]      sum_idx;
  logic [IDW-1:0]    winner;
  logic              found;
  logic              slot_free;
  logic              grant;

  // Rotate the valid vector so that bit 0 corresponds to ptr_q. The first set bit
  // in this rotated vector is the round-robin winner.
  // NOTE: every variable assigned in this always_comb block gets a default value first.
  // Otherwise a path that does not assign the variable would infer a latch.
  always_comb begin
    valid_rot = {req_valid, req_valid} >> ptr_q;
    winner    = '0;
    found     = 1'b0;
    sum_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && valid_rot[k]) begin
        found   = 1'b1;
        sum_idx = {1'b0, ptr_q} + (IDW+1)'(k);
        winner  = (sum_idx >= (IDW+1)'(NREQ)) ? IDW'(sum_idx - (IDW+1)'(NREQ))
                                              : IDW'(sum_idx);
      end
    end
  end

  // Reset also gates the grant, so req_ready and the adder inputs read zero while reset is asserted.
  assign slot_free = !rsp_valid_q || rsp_ready;
  assign grant     = rst_n && en && slot_free && found;

  always_comb begin
    req_ready = '0;
    add_a     = 16'h0000;
    add_b     = 16'h0000;
    for (int i = 0; i < NREQ; i++) begin
      if (grant && (winner == IDW'(i))) begin
        req_ready[i] = 1'b1;
        add_a        = req_a[16*i +: 16];
        add_b        = req_b[16*i +: 16];
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    ops_total_d = ops_total_q;
    if (grant) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = add_o;
      rsp_id_d    = winner;
      ptr_d       = (winner == IDW'(NREQ-1)) ? '0 : winner + IDW'(1);
      ops_total_d = ops_total_q + 16'd1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments. All flops therefore update
  // together at the clock edge, regardless of the order in which the blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      ops_total_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      ops_total_q <= ops_total_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign ops_total = ops_total_q;
  assign busy      = rsp_valid_q || (en && (|req_valid));

endmodule

// File: tb/tb_add16u_share_arb.sv
// Self-checking bench for add16u_share_arb. An exact adder is attached to the adder port.
// A transaction-level model is compared with the DUT on every falling edge, and directed steps pin literal values.
module tb_add16u_share_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic                rsp_ready = 1'b0;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [16*NREQ-1:0]  req_a, req_b;
  logic [15:0]         add_a, add_b, ops_total;
  logic [16:0]         add_o, rsp_data;
  logic                rsp_valid, busy;
  logic [IDW-1:0]      rsp_id;

  logic        v     [NREQ];
  logic [15:0] op_a  [NREQ];
  logic [15:0] op_b  [NREQ];
  int          n_vec = 0;
  int          n_err = 0;
  bit          chk_on = 1'b0;

  always_comb begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_valid[k]       = v[k];
      req_a[16*k +: 16]  = op_a[k];
      req_b[16*k +: 16]  = op_b[k];
    end
  end

  assign add_o = {1'b0, add_a} + {1'b0, add_b};

  add16u_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_o(add_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .ops_total(ops_total), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the next requester served is the valid one at the smallest circular distance
  // from the one after the last served.
  int          m_ptr;
  logic        m_valid;
  logic [16:0] m_data;
  int          m_id;
  logic [15:0] m_ops;

  function automatic int m_pick();
    int best = -1;
    int bd   = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (v[i]) begin
        int d;
        d = (i - m_ptr + NREQ) % NREQ;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic m_grant();
    return rst_n && en && (!m_valid || rsp_ready) && (m_pick() >= 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr   <= 0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_id    <= 0;
      m_ops   <= '0;
    end else begin : upd
      int w;
      w = m_pick();
      if (m_grant()) begin
        m_valid <= 1'b1;
        m_data  <= 17'(op_a[w]) + 17'(op_b[w]);
        m_id    <= w;
        m_ptr   <= (w + 1) % NREQ;
        m_ops   <= m_ops + 16'd1;
      end else if (rsp_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_on) begin : cmp
      int              w;
      logic            g;
      logic [NREQ-1:0] er;
      logic [15:0]     ea, eb;
      w  = m_pick();
      g  = m_grant();
      er = '0;
      ea = '0;
      eb = '0;
      if (g) begin
        er[w] = 1'b1;
        ea    = op_a[w];
        eb    = op_b[w];
      end
      check("m.req_ready", 32'(req_ready), 32'(er));
      check("m.add_a", 32'(add_a), 32'(ea));
      check("m.add_b", 32'(add_b), 32'(eb));
      check("m.rsp_valid", 32'(rsp_valid), 32'(m_valid));
      check("m.rsp_data", 32'(rsp_data), 32'(m_data));
      check("m.rsp_id", 32'(rsp_id), 32'(m_id));
      check("m.ops_total", 32'(ops_total), 32'(m_ops));
      check("m.busy", 32'(busy), 32'(m_valid || (en && (w >= 0))));
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic val);
    for (int k = 0; k < NREQ; k++) v[k] = val;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      v[k]    = 1'b0;
      op_a[k] = 16'h0000;
      op_b[k] = 16'h0000;
    end
    #1;
    // During reset, the DUT must hold all outputs at zero even with live requests.
    set_all(1'b1);
    en = 1'b1;
    rsp_ready = 1'b1;
    op_a[0] = 16'hABCD;
    #1;
    check("rst.req_ready", 32'(req_ready), 32'h0);
    check("rst.add_a", 32'(add_a), 32'h0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst.rsp_data", 32'(rsp_data), 32'h0);
    check("rst.rsp_id", 32'(rsp_id), 32'h0);
    check("rst.ops_total", 32'(ops_total), 32'h0);
    set_all(1'b0);
    op_a[0] = 16'h0000;
    next();
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // Single request
    v[1] = 1'b1; op_a[1] = 16'h1234; op_b[1] = 16'h0FFF;
    @(negedge clk);
    check("single.req_ready", 32'(req_ready), 32'b0010);
    next();
    v[1] = 1'b0;
    @(negedge clk);
    check("single.rsp_valid", 32'(rsp_valid), 32'h1);
    check("single.rsp_data", 32'(rsp_data), 32'h02233);
    check("single.rsp_id", 32'(rsp_id), 32'h1);
    check("single.ops_total", 32'(ops_total), 32'h1);
    rst_n = 1'b0;
    next();
    rst_n = 1'b1;

    // Round-robin from reset
    for (int k = 0; k < NREQ; k++) begin
      v[k]    = 1'b1;
      op_a[k] = 16'(16'h1000 * (k + 1));
      op_b[k] = 16'(k);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("rr.req_ready", 32'(req_ready), 32'(1 << (c % 4)));
      if (c > 0) begin
        check("rr.rsp_valid", 32'(rsp_valid), 32'h1);
        check("rr.rsp_id", 32'(rsp_id), 32'((c - 1) % 4));
      end
      next();
    end
    set_all(1'b0);
    next();

    // Pointer rotation: after 2 is served, 3 comes before 0
    v[2] = 1'b1;
    @(negedge clk);
    check("rot.grant2", 32'(req_ready), 32'b0100);
    next();
    v[2] = 1'b0; v[0] = 1'b1; v[3] = 1'b1;
    @(negedge clk);
    check("rot.grant3", 32'(req_ready), 32'b1000);
    next();
    v[3] = 1'b0;
    @(negedge clk);
    check("rot.grant0", 32'(req_ready), 32'b0001);
    next();
    v[0] = 1'b0;
    next();

    // Backpressure with a held 0x1FFFE result
    v[2] = 1'b1; op_a[2] = 16'hFFFF; op_b[2] = 16'hFFFF;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp.grant2", 32'(req_ready), 32'b0100);
    next();
    v[2] = 1'b0;
    v[1] = 1'b1; op_a[1] = 16'h0001; op_b[1] = 16'h0002;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp.req_ready", 32'(req_ready), 32'h0);
      check("bp.add_a", 32'(add_a), 32'h0);
      check("bp.rsp_valid", 32'(rsp_valid), 32'h1);
      check("bp.rsp_data", 32'(rsp_data), 32'h1FFFE);
      next();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp.release_grant", 32'(req_ready), 32'b0010);
    next();
    v[1] = 1'b0;
    @(negedge clk);
    check("bp.new_data", 32'(rsp_data), 32'h00003);
    check("bp.new_id", 32'(rsp_id), 32'h1);

    // en low: no grants, count frozen, pending result drains
    set_all(1'b1);
    en = 1'b0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("en.req_ready", 32'(req_ready), 32'h0);
      check("en.ops_total", 32'(ops_total), 32'd10);
      check("en.rsp_valid", 32'(rsp_valid), 32'h1);
      check("en.busy", 32'(busy), 32'h1);
      next();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("en.req_ready_drain", 32'(req_ready), 32'h0);
    next();
    @(negedge clk);
    check("en.drained", 32'(rsp_valid), 32'h0);
    check("en.ops_frozen", 32'(ops_total), 32'd10);
    check("en.idle", 32'(busy), 32'h0);
    next();

    // Reset mid-operation
    rst_n = 1'b0;
    next();
    rst_n = 1'b1;
    en = 1'b1;
    for (int c = 0; c < 5; c++) next();
    set_all(1'b0);
    rsp_ready = 1'b0;
    @(negedge clk);
    check("mid.ops5", 32'(ops_total), 32'h5);
    check("mid.valid", 32'(rsp_valid), 32'h1);
    #2;
    set_all(1'b1);
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid.rst_valid", 32'(rsp_valid), 32'h0);
    check("mid.rst_ops", 32'(ops_total), 32'h0);
    check("mid.rst_data", 32'(rsp_data), 32'h0);
    check("mid.rst_ready", 32'(req_ready), 32'h0);
    check("mid.rst_add_b", 32'(add_b), 32'h0);
    next();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid.first_grant", 32'(req_ready), 32'b0001);
    next();
    set_all(1'b0);
    next();
    next();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
